// File: rtl/mem_stage_if.sv
// Execute-side op and writeback-side result bundle of the memory stage.
// The stage itself takes the slave view; the upstream/downstream driver takes master.
interface mem_stage_if #(
  parameter int XLEN = 64
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic            mem_read_i;
  logic            mem_write_i;
  logic            mem_to_reg_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] mem_addr_i;
  logic [XLEN-1:0] wr_data_i;
  logic [XLEN-1:0] alu_result_i;
  logic            reg_write_i;
  logic [4:0]      rd_addr_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] rd_data_o;
  logic [4:0]      rd_addr_o;
  logic            reg_write_o;
  logic            fault_o;

  modport slave (
    input  in_valid_i, mem_read_i, mem_write_i, mem_to_reg_i, funct3_i,
           mem_addr_i, wr_data_i, alu_result_i, reg_write_i, rd_addr_i, out_ready_i,
    output in_ready_o, out_valid_o, rd_data_o, rd_addr_o, reg_write_o, fault_o
  );

  modport master (
    output in_valid_i, mem_read_i, mem_write_i, mem_to_reg_i, funct3_i,
           mem_addr_i, wr_data_i, alu_result_i, reg_write_i, rd_addr_i, out_ready_i,
    input  in_ready_o, out_valid_o, rd_data_o, rd_addr_o, reg_write_o, fault_o
  );
endinterface

// File: rtl/mem_stage.sv
// RISC-V memory stage: byte-lane data RAM with sized aligned loads/stores,
// sign/zero extension and valid/ready handshakes toward execute and writeback.
module mem_stage #(
  parameter int XLEN        = 64,
  parameter int DEPTH_WORDS = 512,
  parameter int AW          = $clog2(DEPTH_WORDS * XLEN / 8)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  mem_stage_if.slave bus
);
  localparam int NB   = XLEN / 8;
  localparam int OB   = $clog2(NB);
  localparam int WIW  = AW - OB;
  localparam bit IS32 = (XLEN == 32);

  typedef enum logic [1:0] {IDLE, LOAD, VALID} state_t;

  state_t          state_reg, state_next;
  logic            in_ready, out_valid, accept, handshake;
  logic [OB-1:0]   off;
  logic [WIW-1:0]  widx;
  logic            illegal, misaligned, fault, load_ok, store_ok;
  logic [7:0]      be_base;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wr_shifted;

  logic [XLEN-1:0] rd_data_reg;
  logic [4:0]      rd_addr_reg;
  logic            reg_write_reg, fault_reg;
  logic [OB-1:0]   ld_off_reg;
  logic [2:0]      ld_funct3_reg;
  logic            ld_m2r_reg;

  logic [XLEN-1:0] rd_word, ld_shift, ld_mask, load_ext;
  logic [6:0]      nbits;
  logic            sbit;

  // Upper address bits are deliberately ignored so accesses wrap on RAM size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.mem_addr_i[XLEN-1:AW];

  assign accept    = bus.in_valid_i & in_ready;
  assign handshake = out_valid & bus.out_ready_i;

  always_comb begin
    off  = bus.mem_addr_i[OB-1:0];
    widx = bus.mem_addr_i[AW-1:OB];
    unique case (bus.funct3_i[1:0])
      2'd0:    begin misaligned = 1'b0;                  be_base = 8'h01; end
      2'd1:    begin misaligned = bus.mem_addr_i[0];     be_base = 8'h03; end
      2'd2:    begin misaligned = |bus.mem_addr_i[1:0];  be_base = 8'h0F; end
      default: begin misaligned = |bus.mem_addr_i[2:0];  be_base = 8'hFF; end
    endcase
    illegal = 1'b0;
    if (bus.mem_read_i && bus.mem_write_i)
      illegal = 1'b1;
    else if (bus.mem_read_i)
      illegal = (bus.funct3_i == 3'b111) ||
                (IS32 && (bus.funct3_i == 3'b011 || bus.funct3_i == 3'b110));
    else if (bus.mem_write_i)
      illegal = bus.funct3_i[2] || (IS32 && bus.funct3_i == 3'b011);
    fault      = illegal | ((bus.mem_read_i | bus.mem_write_i) & misaligned);
    load_ok    = bus.mem_read_i & ~fault;
    store_ok   = accept & bus.mem_write_i & ~fault & ~rst_i;
    be         = be_base[NB-1:0] << off;
    wr_shifted = bus.wr_data_i << {off, 3'b000};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = load_ok ? LOAD : VALID;
      LOAD:    state_next = VALID;
      VALID: begin
        if (accept)         state_next = load_ok ? LOAD : VALID;
        else if (handshake) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // in_ready only looks at out_ready in VALID: a held result blocks new ops.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE:  in_ready = 1'b1;
      VALID: begin
        in_ready  = bus.out_ready_i;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // One byte-wide RAM per lane so stores touch only their enabled bytes.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] ram [DEPTH_WORDS];
      logic [7:0] rd_q;
      always_ff @(posedge clk_i) begin
        if (store_ok && be[gi]) ram[widx] <= wr_shifted[gi*8 +: 8];
        if (accept && load_ok)  rd_q <= ram[widx];
      end
      assign rd_word[gi*8 +: 8] = rd_q;
    end
  endgenerate

  always_comb begin
    ld_shift = rd_word >> {ld_off_reg, 3'b000};
    nbits    = 7'd8 << ld_funct3_reg[1:0];
    ld_mask  = ~({XLEN{1'b1}} << nbits);
    case (ld_funct3_reg[1:0])
      2'd0:    sbit = ld_shift[7];
      2'd1:    sbit = ld_shift[15];
      2'd2:    sbit = ld_shift[31];
      default: sbit = ld_shift[XLEN-1];
    endcase
    load_ext = ld_shift & ld_mask;
    if (!ld_funct3_reg[2] && sbit) load_ext = load_ext | ~ld_mask;
  end

  // Non-load results settle at accept; load data replaces it on leaving LOAD.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_reg   <= '0;
      rd_addr_reg   <= '0;
      reg_write_reg <= 1'b0;
      fault_reg     <= 1'b0;
      ld_off_reg    <= '0;
      ld_funct3_reg <= '0;
      ld_m2r_reg    <= 1'b0;
    end else if (accept) begin
      rd_addr_reg   <= bus.rd_addr_i;
      reg_write_reg <= bus.reg_write_i & ~fault;
      fault_reg     <= fault;
      ld_off_reg    <= off;
      ld_funct3_reg <= bus.funct3_i;
      ld_m2r_reg    <= bus.mem_to_reg_i;
      rd_data_reg   <= (!fault && bus.mem_to_reg_i) ? bus.alu_result_i : '0;
    end else if (state_reg == LOAD && !ld_m2r_reg) begin
      rd_data_reg <= load_ext;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.rd_data_o   = rd_data_reg;
  assign bus.rd_addr_o   = rd_addr_reg;
  assign bus.reg_write_o = reg_write_reg;
  assign bus.fault_o     = fault_reg;
endmodule

// File: tb/tb_mem_stage.sv
// Random plus directed stimulus for mem_stage, scored against a byte-array
// memory model that applies the load/store/fault rules arithmetically.
module tb_mem_stage;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if #(.XLEN(XLEN)) ifc ();
  mem_stage #(.XLEN(XLEN), .DEPTH_WORDS(512)) dut (.clk_i(clk), .rst_i(rst), .bus(ifc));

  typedef struct {
    logic rd, wr, m2r, regw;
    logic [2:0] f3;
    logic [63:0] addr, wdata, alu;
    logic [4:0] rda;
    logic has_ref;
    logic [63:0] ref_data;
    logic ref_fault;
  } op_t;

  typedef struct {
    logic [63:0] data;
    logic [4:0] rda;
    logic regw, fault;
    int lat, acc_cycle, id;
    logic has_ref;
    logic [63:0] ref_data;
    logic ref_fault;
  } exp_t;

  op_t  op_q[$];
  exp_t exp_q[$];
  logic [7:0] mem_m [int];
  int n_checks = 0, n_pass = 0;
  int cycle = 0, n_ids = 0;
  bit head_seen = 0, hold_vld = 0;
  logic [63:0] s_data;
  logic [4:0]  s_rda;
  logic        s_regw, s_fault;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  task automatic push_op(input logic rd, input logic wr, input logic m2r, input logic regw,
                         input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] alu, input logic [4:0] rda, input logic has_ref,
                         input logic [63:0] ref_data, input logic ref_fault);
    op_t o;
    o.rd = rd; o.wr = wr; o.m2r = m2r; o.regw = regw; o.f3 = f3; o.addr = addr;
    o.wdata = wdata; o.alu = alu; o.rda = rda; o.has_ref = has_ref;
    o.ref_data = ref_data; o.ref_fault = ref_fault;
    op_q.push_back(o);
  endtask

  // Reference: fault rules, byte memory and extension from access size.
  task automatic model_accept(input op_t o);
    exp_t e;
    int sz, a;
    bit illegal, flt;
    logic [63:0] v;
    sz = 1 << o.f3[1:0];
    a  = int'(o.addr % 64'd4096);
    illegal = (o.rd && o.wr) || (o.rd && o.f3 == 3'd7) || (o.wr && o.f3 > 3'd3);
    flt = illegal || ((o.rd || o.wr) && (a % sz != 0));
    v = 64'd0;
    if (o.wr && !flt)
      for (int i = 0; i < sz; i++) mem_m[a + i] = 8'(o.wdata >> (8 * i));
    if (o.rd && !flt) begin
      for (int i = 0; i < sz; i++) v = v | (64'(mem_m[a + i]) << (8 * i));
      if (o.f3 < 3'd4 && sz < 8 && ((v >> (8 * sz - 1)) & 64'd1) != 64'd0)
        v = v | ~((64'd1 << (8 * sz)) - 64'd1);
    end
    e.data = flt ? 64'd0 : (o.m2r ? o.alu : (o.rd ? v : 64'd0));
    e.rda = o.rda; e.regw = o.regw && !flt; e.fault = flt;
    e.lat = (o.rd && !flt) ? 2 : 1; e.acc_cycle = cycle; e.id = n_ids++;
    e.has_ref = o.has_ref; e.ref_data = o.ref_data; e.ref_fault = o.ref_fault;
    exp_q.push_back(e);
  endtask

  task automatic drive_head();
    if (op_q.size() != 0) begin
      ifc.in_valid_i   = 1'b1;
      ifc.mem_read_i   = op_q[0].rd;
      ifc.mem_write_i  = op_q[0].wr;
      ifc.mem_to_reg_i = op_q[0].m2r;
      ifc.reg_write_i  = op_q[0].regw;
      ifc.funct3_i     = op_q[0].f3;
      ifc.mem_addr_i   = op_q[0].addr;
      ifc.wr_data_i    = op_q[0].wdata;
      ifc.alu_result_i = op_q[0].alu;
      ifc.rd_addr_i    = op_q[0].rda;
    end else begin
      ifc.in_valid_i = 1'b0;
    end
  endtask

  // Observe at the falling edge what the coming rising edge will do.
  task automatic tick(output bit accepted);
    exp_t e;
    @(negedge clk);
    cycle++;
    if (hold_vld) begin
      check_eq("hold_valid", 64'(ifc.out_valid_o), 64'd1);
      check_eq("hold_data", ifc.rd_data_o, s_data);
      check_eq("hold_rd_addr", 64'(ifc.rd_addr_o), 64'(s_rda));
      check_eq("hold_reg_write", 64'(ifc.reg_write_o), 64'(s_regw));
      check_eq("hold_fault", 64'(ifc.fault_o), 64'(s_fault));
    end
    hold_vld = 0;
    if (ifc.out_valid_o) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 64'(ifc.out_valid_o), 64'd0);
      end else begin
        e = exp_q[0];
        if (!head_seen) begin
          check_eq("latency", 64'(cycle - e.acc_cycle), 64'(e.lat));
          head_seen = 1;
        end
        if (ifc.out_ready_i) begin
          $display("[%0d] result %0d rd=%0d data=0x%016h we=%0b fault=%0b", cycle, e.id,
                   ifc.rd_addr_o, ifc.rd_data_o, ifc.reg_write_o, ifc.fault_o);
          check_eq("rd_data", ifc.rd_data_o, e.data);
          check_eq("rd_addr", 64'(ifc.rd_addr_o), 64'(e.rda));
          check_eq("reg_write", 64'(ifc.reg_write_o), 64'(e.regw));
          check_eq("fault", 64'(ifc.fault_o), 64'(e.fault));
          if (e.has_ref) begin
            check_eq("ref_data", ifc.rd_data_o, e.ref_data);
            check_eq("ref_fault", 64'(ifc.fault_o), 64'(e.ref_fault));
          end
          void'(exp_q.pop_front());
          head_seen = 0;
        end else begin
          check_eq("stall_in_ready", 64'(ifc.in_ready_o), 64'd0);
          s_data = ifc.rd_data_o; s_rda = ifc.rd_addr_o;
          s_regw = ifc.reg_write_o; s_fault = ifc.fault_o;
          hold_vld = 1;
        end
      end
    end
    accepted = ifc.in_valid_i && ifc.in_ready_o;
    if (accepted && op_q.size() != 0) model_accept(op_q[0]);
    @(posedge clk);
    #1;
  endtask

  // ready_mode: 0 = always ready, 1 = random, 2 = low only at cycle stall_cyc.
  task automatic drain(input int ready_mode, input int stall_cyc);
    int cyc;
    bit acc;
    cyc = 0;
    while ((op_q.size() != 0 || exp_q.size() != 0) && cyc < 4000) begin
      drive_head();
      case (ready_mode)
        1:       ifc.out_ready_i = ($urandom_range(0, 3) != 0);
        2:       ifc.out_ready_i = (cyc != stall_cyc);
        default: ifc.out_ready_i = 1'b1;
      endcase
      tick(acc);
      if (acc) void'(op_q.pop_front());
      cyc++;
    end
    if (cyc >= 4000) check_eq("drain_timeout", 64'(cyc), 64'd0);
    ifc.in_valid_i  = 1'b0;
    ifc.out_ready_i = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check_eq({tag, "_out_valid"}, 64'(ifc.out_valid_o), 64'd0);
    check_eq({tag, "_in_ready"}, 64'(ifc.in_ready_o), 64'd1);
    check_eq({tag, "_fault"}, 64'(ifc.fault_o), 64'd0);
    check_eq({tag, "_reg_write"}, 64'(ifc.reg_write_o), 64'd0);
    check_eq({tag, "_rd_data"}, ifc.rd_data_o, 64'd0);
    check_eq({tag, "_rd_addr"}, 64'(ifc.rd_addr_o), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int sz;
    bit acc;
    logic rd, wr;
    logic [2:0] f3;
    logic [63:0] addr;

    rst = 1'b1;
    ifc.in_valid_i = 1'b0; ifc.mem_read_i = 1'b0; ifc.mem_write_i = 1'b0;
    ifc.mem_to_reg_i = 1'b0; ifc.reg_write_i = 1'b0; ifc.funct3_i = 3'd0;
    ifc.mem_addr_i = 64'd0; ifc.wr_data_i = 64'd0; ifc.alu_result_i = 64'd0;
    ifc.rd_addr_i = 5'd0; ifc.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_outputs("reset");

    // SD then LD at 0x40
    push_op(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 64'h40, 64'h1122334455667788, 64'd0, 5'd0, 1'b1, 64'd0, 1'b0);
    push_op(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 64'h40, 64'd0, 64'd0, 5'd5, 1'b1, 64'h1122334455667788, 1'b0);
    drain(0, 0);
    // SB then LB / LBU / LD
    push_op(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 64'h43, 64'hAA, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0);
    push_op(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 64'h43, 64'd0, 64'd0, 5'd6, 1'b1, 64'hFFFFFFFFFFFFFFAA, 1'b0);
    push_op(1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 64'h43, 64'd0, 64'd0, 5'd7, 1'b1, 64'h00000000000000AA, 1'b0);
    push_op(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 64'h40, 64'd0, 64'd0, 5'd8, 1'b1, 64'h11223344AA667788, 1'b0);
    drain(0, 0);
    // misaligned LW and SW, then confirm RAM untouched
    push_op(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 64'h42, 64'd0, 64'd0, 5'd9, 1'b1, 64'd0, 1'b1);
    push_op(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 64'h42, 64'hDEADBEEF, 64'd0, 5'd0, 1'b1, 64'd0, 1'b1);
    push_op(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 64'h40, 64'd0, 64'd0, 5'd10, 1'b1, 64'h11223344AA667788, 1'b0);
    drain(0, 0);
    // four ALU ops with writeback stalled on the third cycle
    for (int i = 1; i <= 4; i++)
      push_op(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 64'd0, 64'd0, 64'(i), 5'(i), 1'b1, 64'(i), 1'b0);
    drain(2, 2);
    // address wrap and illegal funct3
    push_op(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 64'h8010, 64'hCAFEBABE12345678, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0);
    push_op(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 64'h10, 64'd0, 64'd0, 5'd11, 1'b1, 64'hCAFEBABE12345678, 1'b0);
    push_op(1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 64'h10, 64'd0, 64'd0, 5'd12, 1'b1, 64'd0, 1'b1);
    drain(0, 0);

    // reset while a load is in flight
    push_op(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 64'h40, 64'd0, 64'd0, 5'd13, 1'b0, 64'd0, 1'b0);
    drive_head();
    tick(acc);
    if (acc) void'(op_q.pop_front());
    check_eq("rstmid_accept", 64'(acc), 64'd1);
    ifc.in_valid_i = 1'b0;
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    exp_q.delete();
    head_seen = 0;
    hold_vld = 0;
    check_idle_outputs("rstmid");
    push_op(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 64'h40, 64'd0, 64'd0, 5'd14, 1'b1, 64'h11223344AA667788, 1'b0);
    drain(0, 0);

    // fill the random window so every random load reads known bytes
    for (int w = 0; w < 32; w++)
      push_op(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 64'(w * 8), {$urandom(), $urandom()}, 64'd0, 5'd0,
              1'b0, 64'd0, 1'b0);
    drain(0, 0);

    for (int k = 0; k < 400; k++) begin
      kind = $urandom_range(0, 9);
      rd = (kind >= 4 && kind <= 6) || kind == 9;
      wr = (kind >= 7);
      f3 = wr && !rd ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      sz = 1 << f3[1:0];
      addr = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) addr = addr & ~64'(sz - 1);
      if ($urandom_range(0, 7) == 0) addr = addr | (64'($urandom_range(1, 15)) << 12);
      push_op(rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3, addr,
              {$urandom(), $urandom()}, {$urandom(), $urandom()}, 5'($urandom_range(0, 31)),
              1'b0, 64'd0, 1'b0);
    end
    drain(1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised memory stage of the RISC-V pipeline, between execute and writeback. It owns a byte-addressed data RAM and performs sized, aligned loads and stores with sign/zero extension. It selects load data or the ALU result for writeback. Valid/ready handshakes on both sides let it stall the pipeline on load latency and writeback backpressure.

## Interface
- XLEN, 64: datapath width; 32 or 64 only.
- DEPTH_WORDS, 512: RAM depth in XLEN-bit words; power of two.
- AW, log2(DEPTH_WORDS*XLEN/8): derived byte-address bits used.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  execute presents an op.
- in_ready_o  out  1  stage accepts the op this cycle.
- mem_read_i  in  1  op is a load.
- mem_write_i  in  1  op is a store.
- mem_to_reg_i  in  1  0 = writeback load data; 1 = writeback alu_result_i.
- funct3_i  in  3  access size/sign (RV encoding).
- mem_addr_i  in  XLEN  byte address.
- wr_data_i  in  XLEN  store data, LSB-aligned.
- alu_result_i  in  XLEN  execute result.
- reg_write_i  in  1  op writes rd.
- rd_addr_i  in  5  destination register.
- out_valid_o  out  1  writeback result valid.
- out_ready_i  in  1  writeback accepts result.
- rd_data_o  out  XLEN  writeback data.
- rd_addr_o  out  5  registered rd_addr_i.
- reg_write_o  out  1  registered reg_write_i, forced 0 on fault.
- fault_o  out  1  misaligned/illegal access; qualified by out_valid_o.

## Operation
- Accept = in_valid_i & in_ready_o; all inputs are sampled at the accept edge.
- State machine:
  - IDLE: in_ready_o=1. Load accept goes to LOAD. Any other accept goes to VALID.
  - LOAD: in_ready_o=0. Next edge always goes to VALID.
  - VALID: in_ready_o=out_ready_i. Handshake with no accept goes to IDLE. Handshake plus accept goes to LOAD or VALID per the new op (back-to-back). No handshake holds all outputs stable.
- Load funct3: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. Signed forms sign-extend to XLEN; U forms zero-extend.
- Store funct3: 000 SB, 001 SH, 010 SW, 011 SD.
- Illegal ops: any other funct3, and for XLEN=32 also LD/LWU/SD. mem_read_i & mem_write_i together is also illegal.
- Faults:
  - Fault = illegal op, or address not aligned to access size (addr mod size ≠ 0).
  - On fault: no RAM write, rd_data_o=0, reg_write_o=0, fault_o=1.
  - A faulting load goes to VALID directly, not LOAD.
- Stores write only the addressed bytes (byte enables from addr[log2(XLEN/8)-1:0] and size) at the accept edge. Other bytes are unchanged; no read-modify-write.
- Address bits ≥ AW are ignored: addresses wrap modulo RAM size.
- Non-load ops: rd_data_o = alu_result_i if mem_to_reg_i=1, else 0.
- Loads: rd_data_o = extended load data if mem_to_reg_i=0, else alu_result_i. The RAM read still occurs.
- RAM read is synchronous, one cycle. A load at address A issued the cycle after a store to A returns the new data.

## Timing
- Reset values: out_valid_o=0, fault_o=0, reg_write_o=0, rd_data_o=0, rd_addr_o=0, state=IDLE. in_ready_o=1 in the cycle after reset.
- Reset mid-operation discards any in-flight load and result. RAM contents are preserved.
- Latency from the accept edge to out_valid_o: 1 cycle for non-load, store or fault; 2 cycles for a valid load.
- Throughput: 1 op/cycle for non-loads with out_ready_i=1. One load every 2 cycles.
- in_ready_o depends combinationally on out_ready_i in VALID only. There is no combinational path from in_valid_i to any output.

## Test plan
- Reset, then SD 0x1122334455667788 to 0x40, then LD 0x40 with out_ready_i=1 → load out_valid_o two cycles after accept, rd_data_o=0x1122334455667788, fault_o=0.
- SB 0xAA to 0x43 after the above, then LB 0x43 → 0xFFFFFFFFFFFFFFAA; LBU 0x43 → 0x00000000000000AA; LD 0x40 → 0x11223344AA667788.
- LW at 0x42 (misaligned) with reg_write_i=1 → 1-cycle latency, fault_o=1, reg_write_o=0, rd_data_o=0. SW to 0x42 leaves RAM unchanged.
- Stream four ALU ops (mem_to_reg_i=1, alu 1,2,3,4) with out_ready_i low on cycle 2 → outputs held stable while stalled, in_ready_o=0 during the stall, results 1,2,3,4 delivered in order with none lost.
- Store to 0x8000+0x10 (beyond RAM), then load 0x10 → returns the stored value (wrap). funct3=111 load → fault_o=1.
- Assert rst_i during LOAD state → out_valid_o=0 on the next cycle, in_ready_o=1, no spurious result. A later load returns pre-reset RAM data.
